jesd204b_sync_controller: RTL and testbench
===========================================

JESD204B_SYNC_CONTROLLER -- requirements
Module: jesd204b_sync_controller

Interface
REQ-001 SHALL have parameter CGS_K_COUNT, default 4: consecutive K28.5 cycles needed to complete code-group sync.
REQ-002 SHALL have parameter ILAS_MF, default 4: LMFC periods of ILAS before entering DATA.
REQ-003 SHALL have parameter ILAS_TIMEOUT_MF, default 2: LMFC periods allowed between SYNC~ release and the first ILAS start.
REQ-004 SHALL have parameter ERR_THRESH, default 4: lane errors within one LMFC period that force resync.
REQ-005 SHALL have port dclk, input, 1 bit: device clock, the only clock, rising edge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-007 SHALL have port i_enable, input, 1 bit: link enable; low forces IDLE.
REQ-008 SHALL have port i_fmlc, input, 1 bit: one-cycle LMFC boundary pulse from the LMFC generator.
REQ-009 SHALL have port i_k28_5, input, 1 bit: lane decoded K28.5 this cycle.
REQ-010 SHALL have port i_ilas_start, input, 1 bit: lane decoded K28.0 (ILAS start) this cycle.
REQ-011 SHALL have port i_lane_err, input, 1 bit: disparity or not-in-table error this cycle.
REQ-012 SHALL have port o_sync_n, output, 1 bit: SYNC~ to the transmitter, low requests sync.
REQ-013 SHALL have port o_sysref_arm, output, 1 bit: one-cycle request to arm SYSREF capture.
REQ-014 SHALL have port o_data_valid, output, 1 bit: high only in DATA.
REQ-015 SHALL have port o_state, output, 3 bits: current state encoding.
REQ-016 SHALL have port o_resync_cnt, output, 8 bits: saturating count of error-driven resyncs.

Function
REQ-017 SHALL implement states IDLE=0, WAIT_LMFC=1, CGS=2, SYNC_REL=3, ILAS=4, DATA=5, all registered, with o_state equal to the current state.
REQ-018 SHALL, in IDLE with i_enable=1, pulse o_sysref_arm for exactly one cycle and go to WAIT_LMFC on the next cycle.
REQ-019 SHALL, in WAIT_LMFC, go to CGS on the cycle after the first i_fmlc=1.
REQ-020 SHALL, in CGS, increment a consecutive-K counter when i_k28_5=1 and clear it when i_k28_5=0.
REQ-021 SHALL leave CGS for SYNC_REL on the cycle the counter reaches CGS_K_COUNT.
REQ-022 SHALL, in SYNC_REL, hold o_sync_n=0 until i_fmlc=1 and then, on the next cycle, set o_sync_n=1 and enter ILAS, so that SYNC~ deasserts aligned to an LMFC boundary.
REQ-023 SHALL, in SYNC_REL, return to CGS with the counter cleared if i_k28_5=0 on the i_fmlc cycle.
REQ-024 SHALL, in ILAS, count i_fmlc pulses starting from the cycle i_ilas_start is first seen, and enter DATA on the cycle after the ILAS_MF-th pulse.
REQ-025 SHALL, if i_ilas_start is not seen within ILAS_TIMEOUT_MF i_fmlc pulses of entering ILAS, drive o_sync_n=0 and return to CGS with the counter cleared.
REQ-026 SHALL, in DATA, hold o_data_valid=1 and o_sync_n=1.
REQ-027 SHALL, in DATA, keep a per-multiframe error count; on an i_fmlc cycle the count loads i_lane_err (0 or 1) instead of accumulating.
REQ-028 SHALL trigger resync when the error count plus i_lane_err reaches ERR_THRESH, with a same-cycle i_fmlc and i_lane_err counting that error toward the new period only.
REQ-029 SHALL, on resync, on the next cycle set o_sync_n=0, clear o_data_valid, increment o_resync_cnt (saturating at 255), and enter CGS.
REQ-030 SHALL, when i_enable=0, enter IDLE on the next cycle from any state, with o_sync_n=0, o_data_valid=0 and o_resync_cnt retained.
REQ-031 SHALL give i_enable=0 priority over every other transition.
REQ-032 SHALL register every output.
REQ-033 SHALL keep o_sync_n=0 in IDLE, WAIT_LMFC, CGS and SYNC_REL.

Reset
REQ-034 SHALL, on rst=1 at a dclk edge, force IDLE, o_sync_n=0, o_sysref_arm=0, o_data_valid=0, o_state=0, o_resync_cnt=0, and clear all internal counters.
REQ-035 SHALL give rst priority over i_enable and every other input, including when rst asserts mid-ILAS or mid-DATA.

Verification
REQ-036 SHALL cover the nominal bring-up: i_enable=1, i_fmlc every 16 cycles, i_k28_5=1 continuously, i_ilas_start 2 cycles after SYNC~ rises -> o_sysref_arm one pulse, o_sync_n rises the cycle after an i_fmlc, o_data_valid=1 after the 4th subsequent i_fmlc, o_state=5.
REQ-037 SHALL cover a broken CGS: K pattern 1,1,1,0,1,1,1,1 -> SYNC_REL entered only after the final 4-run, never after the first 3.
REQ-038 SHALL cover ILAS timeout: no i_ilas_start for 2 i_fmlc pulses after SYNC~ release -> o_sync_n=0, o_state=2, o_resync_cnt unchanged.
REQ-039 SHALL cover error threshold: in DATA, 3 errors then i_fmlc with i_lane_err=1, then 2 more errors -> no resync; a 4th error in the same period -> resync, o_resync_cnt=1, o_state=2.
REQ-040 SHALL cover disable and reset mid-DATA: i_enable=0 -> IDLE next cycle, o_resync_cnt held; rst=1 -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/jesd204b_sync_controller.sv
// JESD204B receiver link synchronisation controller.
// Sequences a lane through code-group sync, SYNC~ release on an LMFC
// boundary, ILAS and DATA, and forces a resync when the per-multiframe
// lane error count reaches a threshold.
module jesd204b_sync_controller #(
  parameter int CGS_K_COUNT     = 4,
  parameter int ILAS_MF         = 4,
  parameter int ILAS_TIMEOUT_MF = 2,
  parameter int ERR_THRESH      = 4
) (
  input  logic       dclk,
  input  logic       rst,
  input  logic       i_enable,
  input  logic       i_fmlc,
  input  logic       i_k28_5,
  input  logic       i_ilas_start,
  input  logic       i_lane_err,
  output logic       o_sync_n,
  output logic       o_sysref_arm,
  output logic       o_data_valid,
  output logic [2:0] o_state,
  output logic [7:0] o_resync_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_LMFC = 3'd1,
    ST_CGS       = 3'd2,
    ST_SYNC_REL  = 3'd3,
    ST_ILAS      = 3'd4,
    ST_DATA      = 3'd5
  } state_t;

  // Counter widths sized so each counter can hold its terminal value.
  localparam int KW = $clog2(CGS_K_COUNT + 1);
  localparam int MW = $clog2(ILAS_MF + 1);
  localparam int TW = $clog2(ILAS_TIMEOUT_MF + 1);
  localparam int EW = $clog2(ERR_THRESH + 1);

  localparam logic [KW-1:0] K_TARGET   = KW'(CGS_K_COUNT);
  localparam logic [MW-1:0] MF_TARGET  = MW'(ILAS_MF);
  localparam logic [TW-1:0] TO_TARGET  = TW'(ILAS_TIMEOUT_MF);
  localparam logic [EW-1:0] ERR_TARGET = EW'(ERR_THRESH);

  state_t        r_state;
  logic [KW-1:0] r_k_cnt;
  logic [MW-1:0] r_mf_cnt;
  logic [TW-1:0] r_to_cnt;
  logic          r_ilas_seen;
  logic [EW-1:0] r_err_cnt;
  logic          r_sync_n;
  logic          r_sysref_arm;
  logic          r_data_valid;
  logic [7:0]    r_resync_cnt;

  logic [KW-1:0] w_k_next;
  logic          w_ilas_seen;
  logic [MW-1:0] w_mf_next;
  logic [TW-1:0] w_to_next;
  logic [EW-1:0] w_err_sum;
  logic          w_err_trip;

  assign w_k_next    = r_k_cnt + KW'(1);
  // ILAS start seen earlier or on this very cycle.
  assign w_ilas_seen = r_ilas_seen | i_ilas_start;
  assign w_mf_next   = r_mf_cnt + MW'(1);
  assign w_to_next   = r_to_cnt + TW'(1);
  // An LMFC pulse opens a new period: a coincident error belongs to it only.
  assign w_err_sum   = i_fmlc ? EW'(i_lane_err) : (r_err_cnt + EW'(i_lane_err));
  assign w_err_trip  = (w_err_sum >= ERR_TARGET);

  assign o_sync_n      = r_sync_n;
  assign o_sysref_arm  = r_sysref_arm;
  assign o_data_valid  = r_data_valid;
  assign o_state       = r_state;
  assign o_resync_cnt  = r_resync_cnt;

  // Link state machine; every output and counter is updated here.
  always_ff @(posedge dclk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_k_cnt      <= '0;
      r_mf_cnt     <= '0;
      r_to_cnt     <= '0;
      r_ilas_seen  <= 1'b0;
      r_err_cnt    <= '0;
      r_sync_n     <= 1'b0;
      r_sysref_arm <= 1'b0;
      r_data_valid <= 1'b0;
      r_resync_cnt <= 8'd0;
    end else if (!i_enable) begin
      // Disable wins over every transition; the resync count is kept.
      r_state      <= ST_IDLE;
      r_k_cnt      <= '0;
      r_mf_cnt     <= '0;
      r_to_cnt     <= '0;
      r_ilas_seen  <= 1'b0;
      r_err_cnt    <= '0;
      r_sync_n     <= 1'b0;
      r_sysref_arm <= 1'b0;
      r_data_valid <= 1'b0;
    end else begin
      r_sysref_arm <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_sysref_arm <= 1'b1;
          r_sync_n     <= 1'b0;
          r_data_valid <= 1'b0;
          r_state      <= ST_WAIT_LMFC;
        end

        ST_WAIT_LMFC: begin
          r_sync_n <= 1'b0;
          if (i_fmlc) begin
            r_k_cnt <= '0;
            r_state <= ST_CGS;
          end
        end

        ST_CGS: begin
          r_sync_n <= 1'b0;
          if (i_k28_5) begin
            r_k_cnt <= w_k_next;
            if (w_k_next == K_TARGET) begin
              r_state <= ST_SYNC_REL;
            end
          end else begin
            r_k_cnt <= '0;
          end
        end

        ST_SYNC_REL: begin
          // SYNC~ only releases on an LMFC boundary with K still present.
          if (i_fmlc) begin
            if (i_k28_5) begin
              r_sync_n    <= 1'b1;
              r_mf_cnt    <= '0;
              r_to_cnt    <= '0;
              r_ilas_seen <= 1'b0;
              r_state     <= ST_ILAS;
            end else begin
              r_sync_n <= 1'b0;
              r_k_cnt  <= '0;
              r_state  <= ST_CGS;
            end
          end else begin
            r_sync_n <= 1'b0;
          end
        end

        ST_ILAS: begin
          r_ilas_seen <= w_ilas_seen;
          if (i_fmlc) begin
            if (w_ilas_seen) begin
              r_mf_cnt <= w_mf_next;
              if (w_mf_next == MF_TARGET) begin
                r_err_cnt    <= '0;
                r_data_valid <= 1'b1;
                r_state      <= ST_DATA;
              end
            end else begin
              r_to_cnt <= w_to_next;
              if (w_to_next == TO_TARGET) begin
                // Transmitter never started ILAS: request sync again.
                r_sync_n <= 1'b0;
                r_k_cnt  <= '0;
                r_state  <= ST_CGS;
              end
            end
          end
        end

        ST_DATA: begin
          if (w_err_trip) begin
            r_sync_n     <= 1'b0;
            r_data_valid <= 1'b0;
            r_k_cnt      <= '0;
            r_err_cnt    <= '0;
            r_state      <= ST_CGS;
            if (r_resync_cnt != 8'hFF) begin
              r_resync_cnt <= r_resync_cnt + 8'd1;
            end
          end else begin
            r_sync_n     <= 1'b1;
            r_data_valid <= 1'b1;
            r_err_cnt    <= w_err_sum;
          end
        end

        default: begin
          r_sync_n     <= 1'b0;
          r_data_valid <= 1'b0;
          r_state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jesd204b_sync_controller.sv
// Bench for jesd204b_sync_controller: directed and randomized scenarios
// checked cycle by cycle against a scenario-level reference model.
module tb_jesd204b_sync_controller;

  localparam int CGS_K     = 4;
  localparam int ILAS_MF_N = 4;
  localparam int ILAS_TO   = 2;
  localparam int ERR_T     = 4;
  localparam int NMAX      = 600;

  localparam int ST_IDLE = 0;
  localparam int ST_WAIT = 1;
  localparam int ST_CGS  = 2;
  localparam int ST_SREL = 3;
  localparam int ST_ILAS = 4;
  localparam int ST_DATA = 5;

  logic       dclk;
  logic       rst;
  logic       i_enable;
  logic       i_fmlc;
  logic       i_k28_5;
  logic       i_ilas_start;
  logic       i_lane_err;
  logic       o_sync_n;
  logic       o_sysref_arm;
  logic       o_data_valid;
  logic [2:0] o_state;
  logic [7:0] o_resync_cnt;

  jesd204b_sync_controller #(
    .CGS_K_COUNT    (CGS_K),
    .ILAS_MF        (ILAS_MF_N),
    .ILAS_TIMEOUT_MF(ILAS_TO),
    .ERR_THRESH     (ERR_T)
  ) dut (
    .dclk        (dclk),
    .rst         (rst),
    .i_enable    (i_enable),
    .i_fmlc      (i_fmlc),
    .i_k28_5     (i_k28_5),
    .i_ilas_start(i_ilas_start),
    .i_lane_err  (i_lane_err),
    .o_sync_n    (o_sync_n),
    .o_sysref_arm(o_sysref_arm),
    .o_data_valid(o_data_valid),
    .o_state     (o_state),
    .o_resync_cnt(o_resync_cnt)
  );

  initial dclk = 1'b0;
  always #5 dclk = ~dclk;

  int n_checks = 0;
  int n_fail   = 0;

  // Scenario stimulus, indexed by the clock edge at which it is sampled.
  bit s_k[NMAX];
  bit s_f[NMAX];
  bit s_i[NMAX];
  bit s_e[NMAX];
  // Expected state / resync count after each edge.
  int exp_st[NMAX];
  int exp_rc[NMAX];
  int ilas_entry;
  int data_entry;
  int rc_now;
  int first_srel;

  task automatic check_eq(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d want=%0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge dclk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic int nth_fmlc(input int from, input int k, input int len);
    int cnt;
    cnt = 0;
    for (int j = from; j < len; j++) begin
      if (s_f[j]) begin
        cnt++;
        if (cnt == k) return j;
      end
    end
    return len;
  endfunction

  // First edge at which CGS_K consecutive K characters starting at 'from' complete.
  function automatic int k_run_end(input int from, input int len);
    int run;
    run = 0;
    for (int j = from; j < len; j++) begin
      run = s_k[j] ? run + 1 : 0;
      if (run == CGS_K) return j;
    end
    return len;
  endfunction

  function automatic int first_ilas(input int from, input int len);
    for (int j = from; j < len; j++) begin
      if (s_i[j]) return j;
    end
    return len;
  endfunction

  function automatic void put(input int j, input int st, input int rc);
    if (j >= 0 && j < NMAX) begin
      exp_st[j] = st;
      exp_rc[j] = rc;
    end
  endfunction

  function automatic void fill(input int a, input int b, input int st, input int rc);
    for (int j = a; j < b && j < NMAX; j++) put(j, st, rc);
  endfunction

  // Walk the link phases over the stimulus (enable held high from IDLE).
  function automatic void predict(input int len, input int rc_in);
    int n, e, s, per, sum, rc;
    bit tripped;
    rc = rc_in;
    ilas_entry = -1;
    data_entry = -1;
    fill(0, len, ST_IDLE, rc);
    put(0, ST_WAIT, rc);
    e = nth_fmlc(1, 1, len);
    fill(1, e, ST_WAIT, rc);
    if (e >= len) return;
    put(e, ST_CGS, rc);
    n = e + 1;
    while (n < len) begin
      e = k_run_end(n, len);
      fill(n, e, ST_CGS, rc);
      if (e >= len) return;
      put(e, ST_SREL, rc);
      n = e + 1;
      e = nth_fmlc(n, 1, len);
      fill(n, e, ST_SREL, rc);
      if (e >= len) return;
      if (!s_k[e]) begin
        put(e, ST_CGS, rc);
        n = e + 1;
        continue;
      end
      put(e, ST_ILAS, rc);
      n = e + 1;
      if (ilas_entry < 0) ilas_entry = e;
      s = first_ilas(n, len);
      e = nth_fmlc(n, ILAS_TO, len);
      if (e < s) begin
        fill(n, e, ST_ILAS, rc);
        put(e, ST_CGS, rc);
        n = e + 1;
        continue;
      end
      if (s >= len) begin
        fill(n, len, ST_ILAS, rc);
        return;
      end
      e = nth_fmlc(s, ILAS_MF_N, len);
      fill(n, e, ST_ILAS, rc);
      if (e >= len) return;
      put(e, ST_DATA, rc);
      n = e + 1;
      if (data_entry < 0) data_entry = e;
      per = n;
      tripped = 1'b0;
      while (n < len && !tripped) begin
        if (s_f[n]) per = n;
        sum = 0;
        for (int j = per; j <= n; j++) sum += int'(s_e[j]);
        if (sum >= ERR_T) begin
          rc = (rc < 255) ? rc + 1 : 255;
          put(n, ST_CGS, rc);
          tripped = 1'b1;
        end else begin
          put(n, ST_DATA, rc);
        end
        n++;
      end
      if (!tripped) return;
    end
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic base_stim(input int pct_k);
    int per, off;
    per = int'($urandom_range(20, 8));
    off = int'($urandom_range(per - 1, 0));
    for (int j = 0; j < NMAX; j++) begin
      s_f[j] = (((j + off) % per) == 0);
      s_k[j] = (int'($urandom_range(99, 0)) < pct_k);
      s_i[j] = 1'b0;
      s_e[j] = 1'b0;
    end
  endtask

  // Place one ILAS start two cycles after the first SYNC~ release.
  task automatic place_ilas();
    predict(NMAX, rc_now);
    if (ilas_entry >= 0 && ilas_entry + 2 < NMAX) s_i[ilas_entry + 2] = 1'b1;
    predict(NMAX, rc_now);
  endtask

  task automatic run_scn(input string name, input int len);
    int l;
    int ex;
    l = (len > NMAX) ? NMAX : len;
    first_srel = -1;
    for (int n = 0; n < l; n++) begin
      rst          = 1'b0;
      i_enable     = 1'b1;
      i_fmlc       = s_f[n];
      i_k28_5      = s_k[n];
      i_ilas_start = s_i[n];
      i_lane_err   = s_e[n];
      tick();
      ex = exp_st[n];
      if (first_srel < 0 && int'(o_state) == ST_SREL) first_srel = n;
      check_eq($sformatf("%s.state@%0d", name, n), int'(o_state), ex);
      check_eq($sformatf("%s.sync_n@%0d", name, n), int'(o_sync_n),
               (ex == ST_ILAS || ex == ST_DATA) ? 1 : 0);
      check_eq($sformatf("%s.dvalid@%0d", name, n), int'(o_data_valid), (ex == ST_DATA) ? 1 : 0);
      check_eq($sformatf("%s.arm@%0d", name, n), int'(o_sysref_arm), (n == 0) ? 1 : 0);
      check_eq($sformatf("%s.resync@%0d", name, n), int'(o_resync_cnt), exp_rc[n]);
    end
    rc_now = exp_rc[l - 1];
    $display("scenario %-12s cycles=%0d end_state=%0d resync_cnt=%0d", name, l, exp_st[l - 1], rc_now);
  endtask

  task automatic idle_step(input string name);
    rst          = 1'b0;
    i_enable     = 1'b0;
    i_fmlc       = 1'($urandom_range(1, 0));
    i_k28_5      = 1'($urandom_range(1, 0));
    i_ilas_start = 1'($urandom_range(1, 0));
    i_lane_err   = 1'($urandom_range(1, 0));
    tick();
    check_eq({name, ".state"}, int'(o_state), ST_IDLE);
    check_eq({name, ".sync_n"}, int'(o_sync_n), 0);
    check_eq({name, ".dvalid"}, int'(o_data_valid), 0);
    check_eq({name, ".arm"}, int'(o_sysref_arm), 0);
    check_eq({name, ".resync"}, int'(o_resync_cnt), rc_now);
    $display("disable %-12s state=%0d resync_cnt=%0d", name, o_state, o_resync_cnt);
  endtask

  task automatic reset_step(input string name, input logic en);
    rst          = 1'b1;
    i_enable     = en;
    i_fmlc       = 1'b1;
    i_k28_5      = 1'b1;
    i_ilas_start = 1'b1;
    i_lane_err   = 1'b1;
    tick();
    rc_now = 0;
    check_eq({name, ".state"}, int'(o_state), ST_IDLE);
    check_eq({name, ".sync_n"}, int'(o_sync_n), 0);
    check_eq({name, ".dvalid"}, int'(o_data_valid), 0);
    check_eq({name, ".arm"}, int'(o_sysref_arm), 0);
    check_eq({name, ".resync"}, int'(o_resync_cnt), 0);
    $display("reset   %-12s state=%0d resync_cnt=%0d", name, o_state, o_resync_cnt);
  endtask

  // Bound the whole run in case the clock or a task stalls.
  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int e1, d, f1;
    int pct_e;
    rst          = 1'b1;
    i_enable     = 1'b0;
    i_fmlc       = 1'b0;
    i_k28_5      = 1'b0;
    i_ilas_start = 1'b0;
    i_lane_err   = 1'b0;
    rc_now       = 0;

    reset_step("rst_init", 1'b0);
    reset_step("rst_over_en", 1'b1);
    idle_step("post_reset");

    // Error threshold: 3 errors, LMFC with an error, 2 more (no trip), then a 4th.
    base_stim(100);
    place_ilas();
    d  = data_entry;
    f1 = nth_fmlc(d + 1, 1, NMAX);
    s_e[d + 1] = 1'b1;
    s_e[d + 2] = 1'b1;
    s_e[d + 3] = 1'b1;
    s_e[f1]     = 1'b1;
    s_e[f1 + 1] = 1'b1;
    s_e[f1 + 2] = 1'b1;
    s_e[f1 + 3] = 1'b1;
    predict(NMAX, rc_now);
    run_scn("err_thresh", f1 + 20);
    check_eq("err_thresh.no_trip_before_4th", exp_st[f1 + 2] == ST_DATA ? int'(1) : int'(0), 1);
    idle_step("after_err");

    // Nominal bring-up, then disable mid-DATA with the resync count held.
    base_stim(100);
    place_ilas();
    run_scn("nominal", data_entry + 20);
    idle_step("dis_mid_data");

    // Broken CGS: K pattern 1,1,1,0,1,1,1,1 right after entering CGS.
    base_stim(100);
    e1 = nth_fmlc(1, 1, NMAX);
    s_k[e1 + 4] = 1'b0;
    place_ilas();
    run_scn("cgs_break", ilas_entry + 5);
    check_eq("cgs_break.first_srel", first_srel, e1 + 8);
    idle_step("after_break");

    // ILAS never starts: timeout back to CGS without counting a resync.
    base_stim(100);
    predict(NMAX, rc_now);
    run_scn("ilas_timeout", ilas_entry + 80);
    idle_step("after_to");

    // Randomized link activity.
    for (int r = 0; r < 6; r++) begin
      base_stim(90);
      case (r % 4)
        0: pct_e = 0;
        1: pct_e = 3;
        2: pct_e = 15;
        default: pct_e = 30;
      endcase
      for (int j = 0; j < NMAX; j++) begin
        s_i[j] = (int'($urandom_range(99, 0)) < 8);
        s_e[j] = (int'($urandom_range(99, 0)) < pct_e);
      end
      predict(NMAX, rc_now);
      run_scn($sformatf("random%0d", r), 400);
      idle_step($sformatf("after_rand%0d", r));
    end

    // Reset mid-DATA.
    base_stim(100);
    place_ilas();
    run_scn("pre_rst_data", data_entry + 10);
    reset_step("rst_mid_data", 1'b1);

    // Reset mid-ILAS.
    base_stim(100);
    predict(NMAX, rc_now);
    run_scn("pre_rst_ilas", ilas_entry + 3);
    reset_step("rst_mid_ilas", 1'b1);
    idle_step("final_idle");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
